misr_bist_compactor: RTL and testbench
======================================

Name: misr_bist_compactor

Overview:
- Parametrised multiple-input signature register with its own BIST session controller.
- Compacts NIN-bit response vectors into an NBIT signature using a configurable feedback polynomial, counts a programmed number of vectors, then compares against a golden signature and reports pass/fail.
- Supports serial scan shift of the signature for chain readout/preload.
- Sits at the output of the unit under test in the BIST wrapper, driven by the pattern-generator controller.

Parameters:
- NBIT, 16: signature width, >= 2.
- NIN, 4: response input width, 1 <= NIN <= NBIT.
- POLY, 16'hD008: feedback taps; bit i set => sig[NBIT-1] XORed into stage i.
- SEED, 16'hFFFF: signature load value at reset and at start.
- CNTW, 16: width of the vector counter and npat.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-low reset
- start  in  1  begin session (pulse); honoured in IDLE or DONE only
- npat  in  CNTW  number of valid vectors to compact, sampled on start
- data_valid  in  1  data_in is a vector to compact this cycle
- data_in  in  NIN  response vector
- golden  in  NBIT  expected signature, sampled in CHECK
- shift_en  in  1  serial shift request; honoured in IDLE or DONE only
- scan_in  in  1  serial input into sig[0] during shift
- scan_out  out  1  sig[NBIT-1], direct from the register
- signature  out  NBIT  current signature register
- pat_cnt  out  CNTW  vectors compacted this session
- busy  out  1  high in RUN and CHECK
- done  out  1  high in DONE
- pass  out  1  comparison result, valid while done=1

Behaviour:
- Reset (rst=0 at posedge): state=IDLE, sig=SEED, pat_cnt=0, npat register=0, pass=0. busy and done decode to 0. Reset mid-session aborts with no residual state.
- Step function: fb = sig[NBIT-1].
  - next[0] = din[0] ^ (POLY[0] & fb).
  - next[i] = sig[i-1] ^ din[i] ^ (POLY[i] & fb), where din[i] = 0 for i >= NIN.
- IDLE:
  - start: sig<=SEED, pat_cnt<=0, latch npat, go RUN; if npat==0, go CHECK instead.
  - Otherwise, if shift_en: shift.
  - start has priority over shift_en.
- RUN:
  - data_valid=1: sig<=step, pat_cnt++. If pat_cnt==npat-1 (last vector), go CHECK.
  - data_valid=0: sig and pat_cnt hold.
  - start and shift_en are ignored.
- CHECK: lasts one cycle. pass<=(sig==golden), go DONE. sig holds.
- DONE:
  - done=1; pass and pat_cnt hold.
  - shift_en shifts (pass unchanged).
  - start begins a new session exactly as from IDLE and clears pass to 0.
- Shift: sig <= {sig[NBIT-2:0], scan_in}. scan_out shows the MSB before the edge, MSB first.
- Latency: last vector sampled at edge k; pass is registered and done rises at edge k+1. With npat==0, done rises 2 edges after start.
- Counter: pat_cnt never wraps inside a session (bounded by npat <= 2^CNTW-1).

Decomposition:
- Package misr_pkg: state enum {IDLE, RUN, CHECK, DONE}; default POLY/SEED constants.
- Sub-module misr_lfsr_step: purely combinational step function (params NBIT, NIN, POLY), reused by the scoreboard model.

Test Plan:
1. Defaults, start with npat=1, data_in=4'h0 valid one cycle -> signature=16'h2FF6; golden=16'h2FF6 gives pass=1, done one edge after the vector.
2. npat=1, data_in=4'hF, golden=16'h2FF6 -> signature=16'h2FF9, pass=0, done=1, pat_cnt=1.
3. npat=2, two zero vectors separated by 3 cycles of data_valid=0 -> signature 16'h2FF6 held during gap, final 16'h5FEC, pat_cnt=2, busy high throughout.
4. npat=0, golden=16'hFFFF -> done after 2 edges, pass=1, signature=16'hFFFF; start/shift_en during RUN ignored.
5. From DONE with signature 16'h2FF9, shift_en 16 cycles, scan_in=0 -> scan_out sequence 0010_1111_1111_1001, final signature 16'h0000, pass unchanged.
6. rst=0 asserted mid-RUN after 1 of 3 vectors -> next cycle state IDLE, signature=16'hFFFF, pat_cnt=0, busy=done=pass=0.

Source files
------------

// File: rtl/misr_pkg.sv
// ---------------------------------------------------------------------------
// misr_pkg
// Shared types and default constants for the MISR BIST compactor.
//   state_e        : session controller states
//   MISR_POLY_DEF  : default 16-bit feedback tap mask
//   MISR_SEED_DEF  : default 16-bit signature seed
// ---------------------------------------------------------------------------
package misr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [15:0] MISR_POLY_DEF = 16'hD008;
    localparam logic [15:0] MISR_SEED_DEF = 16'hFFFF;

endpackage

// File: rtl/misr_lfsr_step.sv
// ---------------------------------------------------------------------------
// misr_lfsr_step
// One combinational MISR compaction step.
//   sig_i  [NBIT] : current signature
//   din_i  [NIN]  : response vector, aligned to stage 0
//   next_o [NBIT] : signature after absorbing din_i
// The MSB is fed back into every stage whose POLY bit is set. Stages at or
// above NIN see no data input.
// ---------------------------------------------------------------------------
module misr_lfsr_step #(
    parameter int              NBIT = 16,
    parameter int              NIN  = 4,
    parameter logic [NBIT-1:0] POLY = misr_pkg::MISR_POLY_DEF
) (
    input  logic [NBIT-1:0] sig_i,
    input  logic [NIN-1:0]  din_i,
    output logic [NBIT-1:0] next_o
);

    logic [NBIT-1:0] din_ext;
    logic            fb;

    assign fb = sig_i[NBIT-1];

    always_comb begin
        din_ext            = '0;
        din_ext[NIN-1:0]   = din_i;
    end

    assign next_o = {sig_i[NBIT-2:0], 1'b0} ^ din_ext ^ (POLY & {NBIT{fb}});

endmodule

// File: rtl/misr_bist_compactor.sv
// ---------------------------------------------------------------------------
// misr_bist_compactor
// Multiple-input signature register with a small BIST session controller.
// A session compacts npat valid response vectors, then compares the
// signature against golden and reports the result until the next start.
// In IDLE/DONE the signature can be scan-shifted (MSB out, scan_in to LSB).
//
// Ports:
//   clk, rst         : clock (rising edge), synchronous active-low reset
//   start, npat      : begin a session of npat vectors (IDLE/DONE only)
//   data_valid, data_in : response vector to compact this cycle
//   golden           : expected signature, sampled in CHECK
//   shift_en, scan_in: serial shift request (IDLE/DONE only) and data
//   scan_out         : signature MSB
//   signature        : current signature register
//   pat_cnt          : vectors compacted this session
//   busy, done, pass : session status; pass valid while done=1
// ---------------------------------------------------------------------------
module misr_bist_compactor
    import misr_pkg::*;
#(
    parameter int              NBIT = 16,
    parameter int              NIN  = 4,
    parameter logic [NBIT-1:0] POLY = MISR_POLY_DEF,
    parameter logic [NBIT-1:0] SEED = MISR_SEED_DEF,
    parameter int              CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [CNTW-1:0] npat,
    input  logic            data_valid,
    input  logic [NIN-1:0]  data_in,
    input  logic [NBIT-1:0] golden,
    input  logic            shift_en,
    input  logic            scan_in,
    output logic            scan_out,
    output logic [NBIT-1:0] signature,
    output logic [CNTW-1:0] pat_cnt,
    output logic            busy,
    output logic            done,
    output logic            pass
);

    state_e          state_q, state_d;
    logic [NBIT-1:0] sig_q,   sig_d;
    logic [CNTW-1:0] cnt_q,   cnt_d;
    logic [CNTW-1:0] npat_q,  npat_d;
    logic            pass_q,  pass_d;
    logic [NBIT-1:0] sig_step;

    misr_lfsr_step #(
        .NBIT (NBIT),
        .NIN  (NIN),
        .POLY (POLY)
    ) u_step (
        .sig_i  (sig_q),
        .din_i  (data_in),
        .next_o (sig_step)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            npat_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            npat_q  <= npat_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        npat_d  = npat_q;
        pass_d  = pass_q;

        unique case (state_q)
            IDLE, DONE: begin
                // start wins over shift_en; a fresh session also drops pass
                if (start) begin
                    sig_d   = SEED;
                    cnt_d   = '0;
                    npat_d  = npat;
                    pass_d  = 1'b0;
                    state_d = (npat == '0) ? CHECK : RUN;
                end else if (shift_en) begin
                    sig_d = {sig_q[NBIT-2:0], scan_in};
                end
            end
            RUN: begin
                if (data_valid) begin
                    sig_d = sig_step;
                    cnt_d = cnt_q + CNTW'(1);
                    // npat_q >= 1 here, so the compare cannot underflow
                    if (cnt_q == npat_q - CNTW'(1)) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                pass_d  = (sig_q == golden);
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign scan_out  = sig_q[NBIT-1];
    assign signature = sig_q;
    assign pat_cnt   = cnt_q;
    assign busy      = (state_q == RUN) || (state_q == CHECK);
    assign done      = (state_q == DONE);
    assign pass      = pass_q;

endmodule

// File: tb/tb_misr_bist_compactor.sv
module tb_misr_bist_compactor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] npat;
    logic        data_valid;
    logic [3:0]  data_in;
    logic [15:0] golden;
    logic        shift_en;
    logic        scan_in;
    logic        scan_out;
    logic [15:0] signature;
    logic [15:0] pat_cnt;
    logic        busy;
    logic        done;
    logic        pass;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [15:0] sig;
        logic        pass;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    misr_bist_compactor dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .npat       (npat),
        .data_valid (data_valid),
        .data_in    (data_in),
        .golden     (golden),
        .shift_en   (shift_en),
        .scan_in    (scan_in),
        .scan_out   (scan_out),
        .signature  (signature),
        .pat_cnt    (pat_cnt),
        .busy       (busy),
        .done       (done),
        .pass       (pass)
    );

    // reference step: shift left, fold data into low bits, apply taps on MSB
    function automatic logic [15:0] m_step(input logic [15:0] s, input logic [3:0] d);
        logic [15:0] n;
        n      = {s[14:0], 1'b0};
        n[3:0] = n[3:0] ^ d;
        if (s[15]) n = n ^ 16'hD008;
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_done(output bit timed_out);
        int n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        timed_out = !done;
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        bit   to;
        wait_done(to);
        tests++;
        if (to) begin
            fails++;
            $display("FAIL %s_done_timeout got done=%b exp 1", tag, done);
        end
        e = exp_q.pop_front();
        tests++;
        if (signature !== e.sig) begin
            fails++;
            $display("FAIL %s_sig got %h exp %h", tag, signature, e.sig);
        end
        tests++;
        if (pass !== e.pass) begin
            fails++;
            $display("FAIL %s_pass got %b exp %b", tag, pass, e.pass);
        end
        tests++;
        if (pat_cnt !== e.cnt) begin
            fails++;
            $display("FAIL %s_cnt got %0d exp %0d", tag, pat_cnt, e.cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        tests++;
        if ({signature, pat_cnt, busy, done, pass, scan_out} !== {16'hFFFF, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL reset got sig=%h cnt=%0d b=%b d=%b p=%b so=%b exp FFFF 0 0 0 0 1",
                     signature, pat_cnt, busy, done, pass, scan_out);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_pass();
        logic [15:0] m;
        npat   = 16'd1;
        golden = 16'h2FF6;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        tests++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL t1_run got busy=%b done=%b exp 1 0", busy, done);
        end
        data_valid = 1'b1;
        data_in    = 4'h0;
        m = m_step(16'hFFFF, 4'h0);
        exp_q.push_back('{sig: m, pass: (m == golden), cnt: 16'd1});
        tick();
        data_valid = 1'b0;
        tests++;
        if (signature !== 16'h2FF6 || done !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL t1_check got sig=%h done=%b busy=%b exp 2FF6 0 1", signature, done, busy);
        end
        tick();
        tests++;
        if (done !== 1'b1 || pass !== 1'b1) begin
            fails++;
            $display("FAIL t1_latency got done=%b pass=%b exp 1 1", done, pass);
        end
        pop_check("t1");
    endtask

    task automatic test_single_fail();
        logic [15:0] m;
        npat   = 16'd1;
        golden = 16'h2FF6;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        tests++;
        if (pass !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL t2_pass_clear got pass=%b done=%b exp 0 0", pass, done);
        end
        data_valid = 1'b1;
        data_in    = 4'hF;
        m = m_step(16'hFFFF, 4'hF);
        exp_q.push_back('{sig: m, pass: (m == golden), cnt: 16'd1});
        tick();
        data_valid = 1'b0;
        pop_check("t2");
        tests++;
        if (signature !== 16'h2FF9 || pass !== 1'b0) begin
            fails++;
            $display("FAIL t2_const got sig=%h pass=%b exp 2FF9 0", signature, pass);
        end
    endtask

    task automatic test_shift();
        logic [15:0] ref_sig;
        logic        p0;
        ref_sig  = 16'h2FF9;
        p0       = pass;
        shift_en = 1'b1;
        scan_in  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tests++;
            if (scan_out !== ref_sig[15]) begin
                fails++;
                $display("FAIL shift_bit%0d got %b exp %b", i, scan_out, ref_sig[15]);
            end
            ref_sig = {ref_sig[14:0], 1'b0};
            tick();
        end
        shift_en = 1'b0;
        tests++;
        if (signature !== 16'h0000 || pass !== p0 || done !== 1'b1) begin
            fails++;
            $display("FAIL shift_final got sig=%h pass=%b done=%b exp 0000 %b 1", signature, pass, done, p0);
        end
    endtask

    task automatic test_gap();
        logic [15:0] m;
        npat   = 16'd2;
        golden = 16'h5FEC;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        m = 16'hFFFF;
        data_valid = 1'b1;
        data_in    = 4'h0;
        m = m_step(m, 4'h0);
        tick();
        data_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (signature !== 16'h2FF6 || pat_cnt !== 16'd1 || busy !== 1'b1) begin
                fails++;
                $display("FAIL gap%0d got sig=%h cnt=%0d busy=%b exp 2FF6 1 1", i, signature, pat_cnt, busy);
            end
            tick();
        end
        data_valid = 1'b1;
        m = m_step(m, 4'h0);
        exp_q.push_back('{sig: m, pass: (m == golden), cnt: 16'd2});
        tick();
        data_valid = 1'b0;
        tests++;
        if (busy !== 1'b1 || signature !== 16'h5FEC) begin
            fails++;
            $display("FAIL gap_end got busy=%b sig=%h exp 1 5FEC", busy, signature);
        end
        pop_check("t3");
    endtask

    task automatic test_ignore_and_zero();
        logic [15:0] m;
        npat   = 16'd2;
        golden = 16'h0000;
        start  = 1'b1;
        tick();
        // start and shift_en must not disturb a running session
        npat     = 16'd0;
        shift_en = 1'b1;
        scan_in  = 1'b0;
        tick();
        tick();
        start    = 1'b0;
        shift_en = 1'b0;
        tests++;
        if (signature !== 16'hFFFF || pat_cnt !== 16'd0 || busy !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL run_ignore got sig=%h cnt=%0d busy=%b done=%b exp FFFF 0 1 0",
                     signature, pat_cnt, busy, done);
        end
        m = 16'hFFFF;
        data_valid = 1'b1;
        data_in = 4'h5;
        m = m_step(m, 4'h5);
        tick();
        data_in = 4'hA;
        m = m_step(m, 4'hA);
        exp_q.push_back('{sig: m, pass: (m == golden), cnt: 16'd2});
        tick();
        data_valid = 1'b0;
        pop_check("t4a");

        npat   = 16'd0;
        golden = 16'hFFFF;
        exp_q.push_back('{sig: 16'hFFFF, pass: 1'b1, cnt: 16'd0});
        start  = 1'b1;
        tick();
        start  = 1'b0;
        tests++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL zero_check got busy=%b done=%b exp 1 0", busy, done);
        end
        tick();
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL zero_latency got done=%b exp 1", done);
        end
        pop_check("t4b");
    endtask

    task automatic test_abort();
        npat   = 16'd3;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        data_valid = 1'b1;
        data_in    = 4'h3;
        tick();
        data_valid = 1'b0;
        tests++;
        if (pat_cnt !== 16'd1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL abort_pre got cnt=%0d busy=%b exp 1 1", pat_cnt, busy);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tests++;
        if ({signature, pat_cnt, busy, done, pass} !== {16'hFFFF, 16'h0, 1'b0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL abort got sig=%h cnt=%0d b=%b d=%b p=%b exp FFFF 0 0 0 0",
                     signature, pat_cnt, busy, done, pass);
        end
        tick();
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || signature !== 16'hFFFF) begin
            fails++;
            $display("FAIL abort_idle got busy=%b done=%b sig=%h exp 0 0 FFFF", busy, done, signature);
        end
    endtask

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        npat       = '0;
        data_valid = 1'b0;
        data_in    = '0;
        golden     = '0;
        shift_en   = 1'b0;
        scan_in    = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_pass();
        test_single_fail();
        test_shift();
        test_gap();
        test_ignore_and_zero();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
